fpu_uart_tx_prog: RTL and testbench



---
 rtl/fpu_uart_pkg.sv | 29 ++
 rtl/fpu_uart_tx_fifo.sv | 55 +++++
 rtl/fpu_uart_tx_prog.sv | 157 +++++++++++++++
 tb/tb_fpu_uart_tx_prog.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_uart_pkg.sv
// Shared types and constants for the instruction-load UART receiver and the
// result-readback transmitter. FPU_UART_TX_PARITY_EN adds the PARITY state.
package fpu_uart_pkg;

    localparam int          BYTES_PER_WORD   = 4;
    localparam logic [15:0] MIN_CLKS_PER_BIT = 16'd2;

`ifdef FPU_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;
`endif

    function automatic logic [15:0] clamp_period(input logic [15:0] cpb);
        return (cpb < MIN_CLKS_PER_BIT) ? MIN_CLKS_PER_BIT : cpb;
    endfunction

endpackage

// File: rtl/fpu_uart_tx_fifo.sv
// Word FIFO feeding the readback transmitter; level is a registered count
// so ready can be derived from it without a combinational path from pop.
module fpu_uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   din,
    output logic [31:0]   dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/fpu_uart_tx_prog.sv
// Result-readback UART transmitter: buffered 32-bit words sent LSB byte
// first as 8N1 frames, or 8E1 when FPU_UART_TX_PARITY_EN is defined.
module fpu_uart_tx_prog
    import fpu_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        i_Clks_Per_Bit,
    input  logic               i_Word_Valid,
    input  logic [31:0]        i_Word,
    output logic               o_Word_Ready,
    output logic               o_Tx_Serial,
    output logic               o_Tx_Active,
    output logic               o_Tx_Done,
    output logic               o_Word_Done,
    output logic [FIFO_AW:0]   o_Fifo_Level
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    uart_state_t state;
    uart_state_t state_d;

    logic [15:0] period;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [31:0] shreg;
    logic        tick;

    logic [31:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        shift;
    logic        tx_done_d;
    logic        word_done_d;

    fpu_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_Word_Valid),
        .pop   (fifo_pop),
        .din   (i_Word),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_Fifo_Level)
    );

    assign o_Word_Ready = !fifo_full;
    assign o_Tx_Active  = (state != IDLE);
    assign tick         = (timer == period - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d     = state;
        fifo_pop    = 1'b0;
        shift       = 1'b0;
        tx_done_d   = 1'b0;
        word_done_d = 1'b0;
        o_Tx_Serial = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                o_Tx_Serial = 1'b0;
                if (tick) state_d = DATA;
            end
            DATA: begin
                o_Tx_Serial = shreg[bit_idx];
                if (tick && bit_idx == 3'd7) begin
`ifdef FPU_UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef FPU_UART_TX_PARITY_EN
            PARITY: begin
                o_Tx_Serial = ^shreg[7:0];
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    tx_done_d = 1'b1;
                    if (byte_idx != LAST_BYTE) begin
                        shift   = 1'b1;
                        state_d = START;
                    end else begin
                        word_done_d = 1'b1;
                        // chain straight into the next word, no idle bit
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer       <= '0;
            period      <= MIN_CLKS_PER_BIT;
            bit_idx     <= '0;
            byte_idx    <= '0;
            shreg       <= '0;
            o_Tx_Done   <= 1'b0;
            o_Word_Done <= 1'b0;
        end else begin
            o_Tx_Done   <= tx_done_d;
            o_Word_Done <= word_done_d;

            if (tick || state == IDLE) timer <= '0;
            else                       timer <= timer + 16'd1;

            if (state == DATA) begin
                if (tick) bit_idx <= bit_idx + 3'd1;
            end else begin
                bit_idx <= '0;
            end

            // bit period is only sampled at byte boundaries
            if (fifo_pop || shift) period <= clamp_period(i_Clks_Per_Bit);

            if (fifo_pop) begin
                shreg    <= fifo_dout;
                byte_idx <= '0;
            end else if (shift) begin
                shreg    <= {8'h00, shreg[31:8]};
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_uart_tx_prog.sv
// Directed bench for fpu_uart_tx_prog: decodes the serial line at mid-bit
// and checks byte order, frame timing, backpressure and reset behaviour.
module tb_fpu_uart_tx_prog;

    localparam int TIMEOUT = 4000;
`ifdef FPU_UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = PAR ? 11 : 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_Clks_Per_Bit;
    logic        i_Word_Valid;
    logic [31:0] i_Word;
    logic        o_Word_Ready;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;
    logic        o_Word_Done;
    logic [2:0]  o_Fifo_Level;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int wd_cnt = 0;
    int wd_cyc = 0;
    int td_cnt = 0;

    fpu_uart_tx_prog dut (
        .clk            (clk),
        .rst            (rst),
        .i_Clks_Per_Bit (i_Clks_Per_Bit),
        .i_Word_Valid   (i_Word_Valid),
        .i_Word         (i_Word),
        .o_Word_Ready   (o_Word_Ready),
        .o_Tx_Serial    (o_Tx_Serial),
        .o_Tx_Active    (o_Tx_Active),
        .o_Tx_Done      (o_Tx_Done),
        .o_Word_Done    (o_Word_Done),
        .o_Fifo_Level   (o_Fifo_Level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_Word_Done === 1'b1) begin
            wd_cnt++;
            wd_cyc = cyc;
        end
        if (o_Tx_Done === 1'b1) td_cnt++;
    end

    task automatic recv_byte(input int per, output logic [7:0] d,
                             output logic p, output logic s, output int t0);
        int n = 0;
        d  = '0;
        p  = 1'b0;
        s  = 1'b0;
        t0 = -1;
        do begin
            @(negedge clk);
            n++;
        end while (o_Tx_Serial !== 1'b0 && n < TIMEOUT);
        if (o_Tx_Serial !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: line=%b after %0d cycles, want start bit",
                     o_Tx_Serial, n);
            return;
        end
        t0 = cyc;
        repeat (per + per / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            d[i] = o_Tx_Serial;
            if (i < 7) repeat (per) @(negedge clk);
        end
        if (PAR) begin
            repeat (per) @(negedge clk);
            p = o_Tx_Serial;
        end
        repeat (per) @(negedge clk);
        s = o_Tx_Serial;
    endtask

    task automatic push_word(input logic [31:0] w, output int pc);
        int n = 0;
        pc = -1;
        @(negedge clk);
        i_Word_Valid = 1'b1;
        i_Word       = w;
        while (o_Word_Ready !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (o_Word_Ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: ready=%b after %0d cycles, want 1",
                     o_Word_Ready, n);
            i_Word_Valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        pc           = cyc;
        i_Word_Valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((o_Tx_Active !== 1'b0 || o_Fifo_Level !== 3'd0) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (o_Tx_Active !== 1'b0 || o_Fifo_Level !== 3'd0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: active=%b level=%0d, want 0/0",
                     o_Tx_Active, o_Fifo_Level);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        i_Clks_Per_Bit = 16'd4;
        i_Word_Valid   = 1'b0;
        i_Word         = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_Tx_Serial !== 1'b1) begin
            errors++;
            $display("FAIL rst_serial got=%b want=1", o_Tx_Serial);
        end
        checks++;
        if (o_Tx_Active !== 1'b0) begin
            errors++;
            $display("FAIL rst_active got=%b want=0", o_Tx_Active);
        end
        checks++;
        if (o_Tx_Done !== 1'b0) begin
            errors++;
            $display("FAIL rst_tx_done got=%b want=0", o_Tx_Done);
        end
        checks++;
        if (o_Word_Done !== 1'b0) begin
            errors++;
            $display("FAIL rst_word_done got=%b want=0", o_Word_Done);
        end
        checks++;
        if (o_Fifo_Level !== 3'd0) begin
            errors++;
            $display("FAIL rst_level got=%0d want=0", o_Fifo_Level);
        end
        checks++;
        if (o_Word_Ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got=%b want=1", o_Word_Ready);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [31:0] w = 32'h12345678;
        logic [7:0]  exp_b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        logic [7:0]  b [4];
        logic        p;
        logic        s [4];
        int          t [4];
        int          pc;
        i_Clks_Per_Bit = 16'd4;
        wd_cnt = 0;
        td_cnt = 0;
        push_word(w, pc);
        for (int i = 0; i < 4; i++) recv_byte(4, b[i], p, s[i], t[i]);
        wait_idle();
        checks++;
        if (t[0] - pc !== 1) begin
            errors++;
            $display("FAIL single_start_latency got=%0d want=1", t[0] - pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b[i] !== exp_b[i] || s[i] !== 1'b1) begin
                errors++;
                $display("FAIL single_byte%0d got=%h stop=%b want=%h stop=1",
                         i, b[i], s[i], exp_b[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (t[i] - t[i-1] !== 4 * FRAME) begin
                errors++;
                $display("FAIL single_byte_len%0d got=%0d want=%0d",
                         i, t[i] - t[i-1], 4 * FRAME);
            end
        end
        checks++;
        if (wd_cnt !== 1 || wd_cyc - t[0] !== 16 * FRAME) begin
            errors++;
            $display("FAIL single_word_done count=%0d at=%0d want count=1 at=%0d",
                     wd_cnt, wd_cyc - t[0], 16 * FRAME);
        end
        checks++;
        if (td_cnt !== 4) begin
            errors++;
            $display("FAIL single_tx_done_count got=%0d want=4", td_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ws [5] = '{32'h11223344, 32'hA5A55A5A, 32'hDEADBEEF,
                                32'h00FF00FF, 32'h80000001};
        logic [7:0]  b [20];
        logic        p;
        logic        s;
        int          t [20];
        int          pcs [5];
        logic [31:0] wv;
        i_Clks_Per_Bit = 16'd4;
        fork
            begin
                for (int k = 0; k < 5; k++) push_word(ws[k], pcs[k]);
                checks++;
                if (o_Word_Ready !== 1'b0 || o_Fifo_Level !== 3'd4) begin
                    errors++;
                    $display("FAIL b2b_full ready=%b level=%0d want ready=0 level=4",
                             o_Word_Ready, o_Fifo_Level);
                end
                checks++;
                if (pcs[4] - pcs[0] !== 4) begin
                    errors++;
                    $display("FAIL b2b_accept_span got=%0d want=4", pcs[4] - pcs[0]);
                end
                @(negedge clk);
                i_Word_Valid = 1'b1;
                i_Word       = 32'hFFFFFFFF;
                repeat (10) @(negedge clk);
                checks++;
                if (o_Fifo_Level !== 3'd4) begin
                    errors++;
                    $display("FAIL b2b_push_while_full level=%0d want=4", o_Fifo_Level);
                end
                i_Word_Valid = 1'b0;
            end
            begin
                for (int j = 0; j < 20; j++) recv_byte(4, b[j], p, s, t[j]);
            end
        join
        wait_idle();
        for (int j = 0; j < 20; j++) begin
            wv = ws[j / 4];
            checks++;
            if (b[j] !== wv[8 * (j % 4) +: 8]) begin
                errors++;
                $display("FAIL b2b_byte%0d got=%h want=%h", j, b[j], wv[8 * (j % 4) +: 8]);
            end
            if (j > 0) begin
                checks++;
                if (t[j] - t[j-1] !== 4 * FRAME) begin
                    errors++;
                    $display("FAIL b2b_gap%0d got=%0d want=%0d",
                             j, t[j] - t[j-1], 4 * FRAME);
                end
            end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] exp_b [4] = '{8'h3C, 8'hC3, 8'h0F, 8'h0F};
        logic [7:0] b [4];
        logic       p;
        logic       s;
        int         t [4];
        int         pc;
        i_Clks_Per_Bit = 16'd1;
        push_word(32'h0F0FC33C, pc);
        for (int i = 0; i < 4; i++) recv_byte(2, b[i], p, s, t[i]);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL clamp_byte%0d got=%h want=%h", i, b[i], exp_b[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (t[i] - t[i-1] !== 2 * FRAME) begin
                errors++;
                $display("FAIL clamp_len%0d got=%0d want=%0d",
                         i, t[i] - t[i-1], 2 * FRAME);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        logic       p;
        logic       s;
        int         t0;
        int         pc;
        int         lows = 0;
        i_Clks_Per_Bit = 16'd4;
        push_word(32'hCAFEB2BE, pc);
        push_word(32'h01020304, pc);
        recv_byte(4, b, p, s, t0);
        while (cyc < t0 + 4 * FRAME + 4 + 4 * 3 + 1) @(negedge clk);
        checks++;
        if (o_Tx_Serial !== 1'b0 || o_Fifo_Level !== 3'd1) begin
            errors++;
            $display("FAIL mid_pre_reset line=%b level=%0d want line=0 level=1",
                     o_Tx_Serial, o_Fifo_Level);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (o_Tx_Serial !== 1'b1 || o_Fifo_Level !== 3'd0 || o_Tx_Active !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset line=%b level=%0d active=%b want 1/0/0",
                     o_Tx_Serial, o_Fifo_Level, o_Tx_Active);
        end
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        td_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (o_Tx_Serial !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0 || td_cnt !== 0 || o_Fifo_Level !== 3'd0) begin
            errors++;
            $display("FAIL mid_residual lows=%0d tx_done=%0d level=%0d want 0/0/0",
                     lows, td_cnt, o_Fifo_Level);
        end
    endtask

    task automatic test_period_change();
        logic [7:0] exp_b [4] = '{8'hC3, 8'hA5, 8'h34, 8'h12};
        logic [7:0] b [4];
        logic       p;
        logic       s;
        int         t [4];
        int         pc;
        i_Clks_Per_Bit = 16'd4;
        push_word(32'h1234A5C3, pc);
        fork
            recv_byte(4, b[0], p, s, t[0]);
            begin
                repeat (12) @(negedge clk);
                i_Clks_Per_Bit = 16'd8;
            end
        join
        for (int i = 1; i < 4; i++) recv_byte(8, b[i], p, s, t[i]);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL cpb_byte%0d got=%h want=%h", i, b[i], exp_b[i]);
            end
        end
        checks++;
        if (t[1] - t[0] !== 4 * FRAME) begin
            errors++;
            $display("FAIL cpb_byte0_len got=%0d want=%0d", t[1] - t[0], 4 * FRAME);
        end
        checks++;
        if (t[2] - t[1] !== 8 * FRAME) begin
            errors++;
            $display("FAIL cpb_byte1_len got=%0d want=%0d", t[2] - t[1], 8 * FRAME);
        end
    endtask

`ifdef FPU_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] exp_b [4] = '{8'h07, 8'h00, 8'h00, 8'h00};
        logic       exp_p [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] b [4];
        logic       p [4];
        logic       s [4];
        int         t [4];
        int         pc;
        i_Clks_Per_Bit = 16'd4;
        push_word(32'h00000007, pc);
        for (int i = 0; i < 4; i++) recv_byte(4, b[i], p[i], s[i], t[i]);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b[i] !== exp_b[i] || p[i] !== exp_p[i] || s[i] !== 1'b1) begin
                errors++;
                $display("FAIL parity_byte%0d got=%h par=%b stop=%b want=%h par=%b stop=1",
                         i, b[i], p[i], s[i], exp_b[i], exp_p[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (t[i] - t[i-1] !== 44) begin
                errors++;
                $display("FAIL parity_len%0d got=%0d want=44", i, t[i] - t[i-1]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_clamp();
        test_mid_reset();
        test_period_change();
`ifdef FPU_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
